// File: rtl/opp_pkg.sv
// opp_pkg: shared types and clamp helper for the multi-channel output preprocessor.
package opp_pkg;
   localparam int P_W_CHAN = 3;
   localparam int P_W_OUT  = 16;
   localparam int P_W_MULT = 8;

   typedef struct packed {
      logic signed [P_W_OUT-1:0] hi;
      logic signed [P_W_OUT-1:0] lo;
      logic signed [P_W_OUT-1:0] init;
      logic [P_W_MULT-1:0]       mult;
   } chan_par_t;

   typedef struct packed {
      logic                v;
      logic [P_W_CHAN-1:0] ch;
      logic                sat;
   } stage_tag_t;

   // Upper bound first, then lower bound, so an inverted window yields lo.
   function automatic logic [P_W_OUT:0] clamp(input logic signed [P_W_OUT-1:0] v,
                                              input logic signed [P_W_OUT-1:0] hi,
                                              input logic signed [P_W_OUT-1:0] lo);
      logic signed [P_W_OUT-1:0] t;
      t = (v > hi) ? hi : v;
      t = (t < lo) ? lo : t;
      return {t != v, t};
   endfunction
endpackage

// File: rtl/signed_saturate.sv
// signed_saturate: narrows a signed value to W_O bits, saturating and flagging overflow.
module signed_saturate #(
   parameter int W_I = 25,
   parameter int W_O = 16
) (
   input  logic signed [W_I-1:0] a,
   output logic signed [W_O-1:0] y,
   output logic                  ovf
);
   localparam logic signed [W_I-1:0] HI = W_I'((2 ** (W_O - 1)) - 1);
   localparam logic signed [W_I-1:0] LO = ~HI;

   always_comb begin
      ovf = (a > HI) || (a < LO);
      y   = ovf ? (a[W_I-1] ? W_O'(LO) : W_O'(HI)) : W_O'(a);
   end
endmodule

// File: rtl/output_preprocessor_mc.sv
// output_preprocessor_mc: 4-stage per-channel scale / accumulate / lock-select / clamp pipeline
// with single-cycle per-channel parameter writes.
module output_preprocessor_mc
   import opp_pkg::*;
#(
   parameter int N_CHAN     = 8,
   parameter int W_CHAN     = P_W_CHAN,
   parameter int W_IN       = 18,
   parameter int W_OUT      = P_W_OUT,
   parameter int W_MULT     = P_W_MULT,
   parameter int OMAX_INIT  = 9999,
   parameter int OMIN_INIT  = 1111,
   parameter int OINIT_INIT = 5000,
   parameter int MULT_INIT  = 1
) (
   input  logic                     clk_in,
   input  logic                     reset_in,
   input  logic signed [W_IN-1:0]   data_in,
   input  logic [W_CHAN-1:0]        chan_in,
   input  logic                     data_valid_in,
   input  logic [N_CHAN-1:0]        lock_en_in,
   input  logic [W_CHAN-1:0]        update_chan_in,
   input  logic signed [W_OUT-1:0]  output_max_in,
   input  logic signed [W_OUT-1:0]  output_min_in,
   input  logic signed [W_OUT-1:0]  output_init_in,
   input  logic [W_MULT-1:0]        multiplier_in,
   input  logic                     update_en_in,
   input  logic                     update_in,
   output logic signed [W_OUT-1:0]  data_out,
   output logic [W_CHAN-1:0]        chan_out,
   output logic                     data_valid_out,
   output logic                     sat_out
);
   localparam int W_P = W_OUT + W_MULT + 1;
   localparam logic [W_CHAN:0] NC = (W_CHAN + 1)'(N_CHAN);

   chan_par_t               par  [N_CHAN];
   logic signed [W_OUT-1:0] prev [N_CHAN];
   stage_tag_t              t1, t2, t3;
   logic signed [W_OUT-1:0] x, r1_x, p, r2_p, prev_rd, s, r3_s, pre, v;
   logic signed [W_P-1:0]   prod;
   logic signed [W_OUT:0]   sum;
   logic                    p_sat, s_sat, c_sat;

   generate
      if (W_OUT < W_IN) begin : g_trunc
         assign x = W_OUT'(data_in >>> (W_IN - W_OUT));
      end else begin : g_ext
         assign x = W_OUT'(data_in);
      end
   endgenerate

   always_comb prod = W_P'(r1_x) * W_P'($signed({1'b0, par[t1.ch].mult}));

   signed_saturate #(.W_I(W_P), .W_O(W_OUT)) u_sat_s2 (.a(prod), .y(p), .ovf(p_sat));

   // S4 result is forwarded so back-to-back samples of one channel see each other.
   always_comb begin
      prev_rd = (t3.v && t3.ch == t2.ch) ? v : prev[t2.ch];
      sum     = (W_OUT + 1)'(r2_p) + (W_OUT + 1)'(prev_rd);
   end

   signed_saturate #(.W_I(W_OUT + 1), .W_O(W_OUT)) u_sat_s3 (.a(sum), .y(s), .ovf(s_sat));

   always_comb begin
      pre        = lock_en_in[t3.ch] ? r3_s : par[t3.ch].init;
      {c_sat, v} = clamp(pre, par[t3.ch].hi, par[t3.ch].lo);
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         t1             <= '0;
         t2             <= '0;
         t3             <= '0;
         data_out       <= '0;
         chan_out       <= '0;
         data_valid_out <= 1'b0;
         sat_out        <= 1'b0;
         for (int i = 0; i < N_CHAN; i++) begin
            par[i]  <= '{hi: W_OUT'(OMAX_INIT), lo: W_OUT'(OMIN_INIT),
                         init: W_OUT'(OINIT_INIT), mult: W_MULT'(MULT_INIT)};
            prev[i] <= W_OUT'(OINIT_INIT);
         end
      end else begin
         t1             <= '{v: data_valid_in && ({1'b0, chan_in} < NC), ch: chan_in, sat: 1'b0};
         r1_x           <= x;
         t2             <= '{v: t1.v, ch: t1.ch, sat: t1.sat | p_sat};
         r2_p           <= p;
         t3             <= '{v: t2.v, ch: t2.ch, sat: t2.sat | s_sat};
         r3_s           <= s;
         data_valid_out <= t3.v;
         if (t3.v) begin
            data_out    <= v;
            chan_out    <= t3.ch;
            sat_out     <= t3.sat | c_sat;
            prev[t3.ch] <= v;
         end
         // A parameter write overrides a same-cycle writeback of prev.
         if (update_in && update_en_in && ({1'b0, update_chan_in} < NC)) begin
            par[update_chan_in]  <= '{hi: output_max_in, lo: output_min_in,
                                      init: output_init_in, mult: multiplier_in};
            prev[update_chan_in] <= output_init_in;
         end
      end
   end
endmodule

// File: tb/tb_output_preprocessor_mc.sv
// tb_output_preprocessor_mc: directed stimulus with a per-cycle behavioural model check
// plus hand-computed literal expectations.
module tb_output_preprocessor_mc;
   logic               clk_in = 1'b0;
   logic               reset_in = 1'b1;
   logic signed [17:0] data_in = '0;
   logic [2:0]         chan_in = '0;
   logic               data_valid_in = 1'b0;
   logic [7:0]         lock_en_in = 8'hFF;
   logic [2:0]         update_chan_in = '0;
   logic signed [15:0] output_max_in = '0;
   logic signed [15:0] output_min_in = '0;
   logic signed [15:0] output_init_in = '0;
   logic [7:0]         multiplier_in = '0;
   logic               update_en_in = 1'b0;
   logic               update_in = 1'b0;
   logic signed [15:0] data_out;
   logic [2:0]         chan_out;
   logic               data_valid_out;
   logic               sat_out;

   always #5 clk_in = ~clk_in;

   output_preprocessor_mc dut (
      .clk_in(clk_in), .reset_in(reset_in), .data_in(data_in), .chan_in(chan_in),
      .data_valid_in(data_valid_in), .lock_en_in(lock_en_in), .update_chan_in(update_chan_in),
      .output_max_in(output_max_in), .output_min_in(output_min_in),
      .output_init_in(output_init_in), .multiplier_in(multiplier_in),
      .update_en_in(update_en_in), .update_in(update_in), .data_out(data_out),
      .chan_out(chan_out), .data_valid_out(data_valid_out), .sat_out(sat_out)
   );

   typedef struct {int ch; int x; int p; int s; bit sat; int age;} ent_t;
   typedef struct {int ch; int d; bit sat;} obs_t;

   int   m_hi[8], m_lo[8], m_ini[8], m_mul[8], m_prev[8];
   ent_t q[$];
   obs_t obs[$];
   bit   e_v, e_sat;
   int   e_d, e_ch;
   int   checks = 0, errors = 0;

   function automatic int lim16(int v);
      return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
   endfunction

   function automatic bit ovf16(int v);
      return v > 32767 || v < -32768;
   endfunction

   task automatic chk(string nm, int got, int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", nm, got, want, $time);
      end
   endtask

   // Each channel's output = clamp(lock ? sat(sat(x*mult) + last output) : init); samples
   // advance one stage per edge, oldest first so a later sample sees an earlier result.
   task automatic model_step();
      ent_t nq[$];
      e_v = 1'b0;
      if (reset_in) begin
         for (int i = 0; i < 8; i++) begin
            m_hi[i] = 9999; m_lo[i] = 1111; m_ini[i] = 5000; m_mul[i] = 1; m_prev[i] = 5000;
         end
         q.delete();
         return;
      end
      foreach (q[i]) begin
         ent_t e;
         int   t, c;
         e = q[i];
         if (e.age == 2) begin
            t = lock_en_in[e.ch] ? e.s : m_ini[e.ch];
            c = t > m_hi[e.ch] ? m_hi[e.ch] : t;
            c = c < m_lo[e.ch] ? m_lo[e.ch] : c;
            e_v = 1'b1; e_d = c; e_ch = e.ch; e_sat = e.sat || (c != t);
            m_prev[e.ch] = c;
         end else begin
            if (e.age == 0) begin
               t = e.x * m_mul[e.ch];
               e.p = lim16(t); e.sat = ovf16(t);
            end else begin
               t = e.p + m_prev[e.ch];
               e.s = lim16(t); e.sat = e.sat | ovf16(t);
            end
            e.age++;
            nq.push_back(e);
         end
      end
      if (update_in && update_en_in) begin
         m_hi[update_chan_in]   = int'(output_max_in);
         m_lo[update_chan_in]   = int'(output_min_in);
         m_ini[update_chan_in]  = int'(output_init_in);
         m_mul[update_chan_in]  = int'(multiplier_in);
         m_prev[update_chan_in] = int'(output_init_in);
      end
      if (data_valid_in)
         nq.push_back('{ch: int'(chan_in), x: int'(data_in >>> 2), p: 0, s: 0, sat: 1'b0, age: 0});
      q = nq;
   endtask

   always @(posedge clk_in) begin
      model_step();
      #1;
      chk("valid", int'(data_valid_out), int'(e_v));
      if (e_v && data_valid_out) begin
         chk("data", int'(data_out), e_d);
         chk("chan", int'(chan_out), e_ch);
         chk("sat", int'(sat_out), int'(e_sat));
      end
      if (data_valid_out) obs.push_back('{ch: int'(chan_out), d: int'(data_out), sat: sat_out});
   end

   task automatic send(int ch, int x);
      @(negedge clk_in);
      chan_in = 3'(ch);
      data_in = 18'(x * 4);
      data_valid_in = 1'b1;
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk_in);
         data_valid_in = 1'b0;
      end
   endtask

   task automatic wr(int ch, int hi, int lo, int ini, int mul, bit en);
      @(negedge clk_in);
      data_valid_in  = 1'b0;
      update_chan_in = 3'(ch);
      output_max_in  = 16'(hi);
      output_min_in  = 16'(lo);
      output_init_in = 16'(ini);
      multiplier_in  = 8'(mul);
      update_en_in   = en;
      update_in      = 1'b1;
      @(negedge clk_in);
      update_in    = 1'b0;
      update_en_in = 1'b0;
   endtask

   task automatic expect_out(string nm, int ch, int d, bit s);
      obs_t o;
      int   n = 0;
      while (obs.size() == 0 && n < 20) begin
         @(posedge clk_in);
         #2;
         n++;
      end
      checks++;
      if (obs.size() == 0) begin
         errors++;
         $display("FAIL %s no output within 20 cycles", nm);
      end else begin
         o = obs.pop_front();
         if (o.ch != ch || o.d != d || o.sat != s) begin
            errors++;
            $display("FAIL %s got ch=%0d data=%0d sat=%0d want ch=%0d data=%0d sat=%0d",
                     nm, o.ch, o.d, o.sat, ch, d, s);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      repeat (2) @(negedge clk_in);
      chk("reset_outs", int'({data_out, chan_out, data_valid_out, sat_out}), 0);
      reset_in = 1'b0;
      // latency: valid must appear on the 4th edge after sampling
      send(2, 4);
      idle(1);
      @(posedge clk_in);
      @(posedge clk_in);
      #1 chk("lat3_valid", int'(data_valid_out), 0);
      @(posedge clk_in);
      #1 chk("lat4_data", data_valid_out ? int'(data_out) : -1, 5004);
      expect_out("ch2_first", 2, 5004, 1'b0);
      send(2, 4);
      idle(1);
      expect_out("ch2_second", 2, 5008, 1'b0);
      // forwarding with back-to-back samples, interleaved channel independence
      wr(0, 9999, 1111, 5000, 2, 1'b1);
      send(0, 100); send(0, 100); send(0, 100);
      idle(1);
      expect_out("fwd_a", 0, 5200, 1'b0);
      expect_out("fwd_b", 0, 5400, 1'b0);
      expect_out("fwd_c", 0, 5600, 1'b0);
      send(0, 100); send(1, 10); send(0, 100); send(1, 10);
      idle(1);
      expect_out("ilv_a", 0, 5800, 1'b0);
      expect_out("ilv_b", 1, 5010, 1'b0);
      expect_out("ilv_c", 0, 6000, 1'b0);
      expect_out("ilv_d", 1, 5020, 1'b0);
      // multiplier saturation and clamping
      wr(3, 9999, 1111, 5000, 255, 1'b1);
      send(3, 32767); send(3, -32768); send(3, 0);
      idle(1);
      expect_out("sat_pos", 3, 9999, 1'b1);
      expect_out("sat_neg", 3, 1111, 1'b1);
      expect_out("at_min", 3, 1111, 1'b0);
      // lock off forces init, re-lock accumulates from it
      wr(5, 9999, 1111, 3000, 1, 1'b1);
      lock_en_in[5] = 1'b0;
      send(5, 77); send(5, -5);
      idle(1);
      expect_out("unlock_a", 5, 3000, 1'b0);
      expect_out("unlock_b", 5, 3000, 1'b0);
      lock_en_in[5] = 1'b1;
      send(5, 7);
      idle(1);
      expect_out("relock", 5, 3007, 1'b0);
      // inverted bounds; disarmed write ignored
      wr(4, 200, 300, 250, 1, 1'b1);
      send(4, 0); send(4, 1000);
      idle(1);
      expect_out("inv_a", 4, 300, 1'b1);
      expect_out("inv_b", 4, 300, 1'b1);
      wr(4, 9999, 1111, 5000, 1, 1'b0);
      send(4, 5);
      idle(1);
      expect_out("no_arm", 4, 300, 1'b1);
      // write coinciding with writeback wins for prev
      send(6, 10);
      idle(2);
      wr(6, 9999, 1111, 4000, 1, 1'b1);
      expect_out("wb_race", 6, 5010, 1'b0);
      send(6, 1);
      idle(1);
      expect_out("wr_wins", 6, 4001, 1'b0);
      // reset mid-stream discards in-flight samples
      send(0, 1); send(1, 1);
      @(negedge clk_in);
      data_valid_in = 1'b0;
      reset_in = 1'b1;
      @(negedge clk_in);
      reset_in = 1'b0;
      idle(6);
      chk("flush_none", obs.size(), 0);
      chk("flush_outs", int'({data_out, chan_out, data_valid_out, sat_out}), 0);
      send(0, 4);
      idle(1);
      expect_out("post_reset", 0, 5004, 1'b0);
      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
